// File: rtl/aes_pkg.sv
// Shared widths and FSM state encoding for the AES block packer.
package aes_pkg;

    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;

    // TOPLA: collecting words; ANAHTAR_BEKLE: block held, waiting for a key;
    // GONDER: block and key presented to the engine.
    typedef enum logic [1:0] {
        TOPLA         = 2'd0,
        ANAHTAR_BEKLE = 2'd1,
        GONDER        = 2'd2
    } state_t;

endpackage

// File: rtl/aes_block_packer_if.sv
// Word-side and engine-side signals of the AES block packer.
// Handshakes: a word moves when s_gecerli & s_hazir are high in the same
// cycle; a block moves when g_gecerli & hazir are high in the same cycle.
// A source holds its payload stable while valid is high and ready is low.
interface aes_block_packer_if;
    import aes_pkg::*;

    logic [WORD_W-1:0]  s_veri;
    logic               s_tur;
    logic               s_gecerli;
    logic               s_hazir;
    logic               temizle;
    logic [BLOCK_W-1:0] anahtar;
    logic [BLOCK_W-1:0] blok;
    logic               g_gecerli;
    logic               hazir;
    logic               anahtar_gecerli;
    logic [15:0]        blok_sayisi;
    state_t             durum;

    // Packer side
    modport slave (
        input  s_veri, s_tur, s_gecerli, temizle, hazir,
        output s_hazir, anahtar, blok, g_gecerli, anahtar_gecerli,
               blok_sayisi, durum
    );

    // Word source / engine side
    modport master (
        output s_veri, s_tur, s_gecerli, temizle, hazir,
        input  s_hazir, anahtar, blok, g_gecerli, anahtar_gecerli,
               blok_sayisi, durum
    );
endinterface

// File: rtl/aes_word_packer.sv
// Assembles four 32-bit words into a 128-bit value. next_value is the
// staged content with the offered word already inserted, so the caller can
// capture a complete block in the same cycle the last word is loaded.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter bit FIRST_WORD_MSB = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               load,
    input  logic [WORD_W-1:0]  word,
    output logic [BLOCK_W-1:0] next_value,
    output logic               last
);

    logic [1:0]         cnt;
    logic [1:0]         slot;
    logic [BLOCK_W-1:0] stage;

    // Place the offered word into the slot selected by the word counter.
    always_comb begin
        slot       = FIRST_WORD_MSB ? (2'd3 - cnt) : cnt;
        next_value = stage;
        next_value[{slot, 5'd0} +: WORD_W] = word;
        last       = (cnt == 2'd3);
    end

    // Staging register and 2-bit word counter; clear wins over load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 2'd0;
            stage <= '0;
        end else if (clear) begin
            cnt   <= 2'd0;
            stage <= '0;
        end else if (load) begin
            cnt   <= cnt + 2'd1;
            stage <= next_value;
        end
    end

endmodule

// File: rtl/aes_block_packer.sv
// Packs 32-bit data and key words into 128-bit block/key pairs for an AES
// engine. blok and anahtar only ever change to complete values.
module aes_block_packer
    import aes_pkg::*;
#(
    parameter bit FIRST_WORD_MSB = 1'b1
) (
    input logic               clk,
    input logic               rst,
    aes_block_packer_if.slave io
);

    state_t             state;
    logic [15:0]        blok_cnt;
    logic               accept;
    logic               data_load;
    logic               key_load;
    logic               data_last;
    logic               key_last;
    logic               data_done;
    logic               key_commit;
    logic               xfer;
    logic [BLOCK_W-1:0] data_next;
    logic [BLOCK_W-1:0] key_next;

    // Ready depends only on state and the type of the offered word.
    always_comb begin
        io.s_hazir = 1'b0;
        case (state)
            TOPLA:         io.s_hazir = 1'b1;
            ANAHTAR_BEKLE: io.s_hazir = io.s_tur;
            default:       io.s_hazir = 1'b0;
        endcase
    end

    // Flush suppresses every accept and transfer in its cycle.
    always_comb begin
        accept     = io.s_gecerli & io.s_hazir & ~io.temizle;
        data_load  = accept & ~io.s_tur;
        key_load   = accept & io.s_tur;
        data_done  = data_load & data_last;
        key_commit = key_load & key_last;
        xfer       = io.g_gecerli & io.hazir & ~io.temizle;
    end

    aes_word_packer #(.FIRST_WORD_MSB(FIRST_WORD_MSB)) u_data (
        .clk        (clk),
        .rst        (rst),
        .clear      (io.temizle),
        .load       (data_load),
        .word       (io.s_veri),
        .next_value (data_next),
        .last       (data_last)
    );

    aes_word_packer #(.FIRST_WORD_MSB(FIRST_WORD_MSB)) u_key (
        .clk        (clk),
        .rst        (rst),
        .clear      (io.temizle),
        .load       (key_load),
        .word       (io.s_veri),
        .next_value (key_next),
        .last       (key_last)
    );

    // Main FSM with registered engine-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= TOPLA;
            io.g_gecerli       <= 1'b0;
            io.anahtar         <= '0;
            io.anahtar_gecerli <= 1'b0;
            io.blok            <= '0;
            blok_cnt           <= 16'd0;
        end else if (io.temizle) begin
            state        <= TOPLA;
            io.g_gecerli <= 1'b0;
        end else begin
            case (state)
                TOPLA: begin
                    if (key_commit) begin
                        io.anahtar         <= key_next;
                        io.anahtar_gecerli <= 1'b1;
                    end
                    if (data_done) begin
                        io.blok <= data_next;
                        if (io.anahtar_gecerli) begin
                            state        <= GONDER;
                            io.g_gecerli <= 1'b1;
                        end else begin
                            state <= ANAHTAR_BEKLE;
                        end
                    end
                end
                ANAHTAR_BEKLE: begin
                    if (key_commit) begin
                        io.anahtar         <= key_next;
                        io.anahtar_gecerli <= 1'b1;
                        state              <= GONDER;
                        io.g_gecerli       <= 1'b1;
                    end
                end
                GONDER: begin
                    if (xfer) begin
                        state        <= TOPLA;
                        io.g_gecerli <= 1'b0;
                        blok_cnt     <= blok_cnt + 16'd1;
                    end
                end
                default: begin
                    state        <= TOPLA;
                    io.g_gecerli <= 1'b0;
                end
            endcase
        end
    end

    assign io.blok_sayisi = blok_cnt;
    assign io.durum       = state;

endmodule

// File: tb/tb_aes_block_packer.sv
// Bench for aes_block_packer: two instances (first word MSB and LSB) share
// one stimulus stream and are checked against a queue-based model.
module tb_aes_block_packer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_block_packer_if if0 ();
  aes_block_packer_if if1 ();

  assign if1.s_veri    = if0.s_veri;
  assign if1.s_tur     = if0.s_tur;
  assign if1.s_gecerli = if0.s_gecerli;
  assign if1.temizle   = if0.temizle;
  assign if1.hazir     = if0.hazir;

  aes_block_packer #(.FIRST_WORD_MSB(1'b1)) u0 (.clk(clk), .rst(rst), .io(if0.slave));
  aes_block_packer #(.FIRST_WORD_MSB(1'b0)) u1 (.clk(clk), .rst(rst), .io(if1.slave));

  // ---------------- reference model ----------------
  logic [31:0]  m_data[$];
  logic [31:0]  m_key[$];
  logic [127:0] m_key1, m_key0, m_blok1, m_blok0;
  bit           m_kv, m_pres;
  logic [15:0]  m_cnt;
  logic [255:0] exp_q1[$];
  logic [255:0] exp_q0[$];

  function automatic logic [127:0] pack(input logic [31:0] w[$], input bit msb);
    logic [127:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (msb) r = {r[95:0], w[i]};
      else     r = {w[i], r[127:32]};
    end
    return r;
  endfunction

  function automatic bit model_ready(input bit tur);
    return !m_pres && (m_data.size() < 4 || tur);
  endfunction

  function automatic state_t model_state();
    if (m_pres) return GONDER;
    if (m_data.size() == 4) return ANAHTAR_BEKLE;
    return TOPLA;
  endfunction

  task automatic model_reset();
    m_data.delete(); m_key.delete();
    m_key1 = '0; m_key0 = '0; m_blok1 = '0; m_blok0 = '0;
    m_kv = 1'b0; m_pres = 1'b0; m_cnt = 16'd0;
    exp_q1.delete(); exp_q0.delete();
  endtask

  task automatic present();
    m_pres = 1'b1;
    exp_q1.push_back({m_blok1, m_key1});
    exp_q0.push_back({m_blok0, m_key0});
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic step(input bit gec, input bit tur, input logic [31:0] veri,
                      input bit hz, input bit tem, output bit acc);
    bit rdy;
    if0.s_gecerli = gec; if0.s_tur = tur; if0.s_veri = veri;
    if0.hazir = hz; if0.temizle = tem;
    #3;
    rdy = model_ready(tur);
    chk("s_hazir_msb", if0.s_hazir, rdy);
    chk("s_hazir_lsb", if1.s_hazir, rdy);
    chk("g_gecerli", if0.g_gecerli, m_pres);
    chk("g_gecerli_lsb", if1.g_gecerli, m_pres);
    chk("anahtar_gecerli", if0.anahtar_gecerli, m_kv);
    chk("anahtar_msb", if0.anahtar, m_key1);
    chk("anahtar_lsb", if1.anahtar, m_key0);
    chk("blok_msb", if0.blok, m_blok1);
    chk("blok_lsb", if1.blok, m_blok0);
    chk("blok_sayisi", if0.blok_sayisi, m_cnt);
    chk("blok_sayisi_lsb", if1.blok_sayisi, m_cnt);
    chk("durum", if0.durum, model_state());
    acc = gec && rdy && !tem;
    @(posedge clk);
    if (tem) begin
      if (m_pres) begin
        void'(exp_q1.pop_back());
        void'(exp_q0.pop_back());
      end
      m_pres = 1'b0; m_data.delete(); m_key.delete();
    end else begin
      if (m_pres && hz) begin
        m_pres = 1'b0; m_data.delete(); m_cnt++;
      end
      if (gec && rdy) begin
        if (tur) begin
          m_key.push_back(veri);
          if (m_key.size() == 4) begin
            m_key1 = pack(m_key, 1'b1); m_key0 = pack(m_key, 1'b0);
            m_kv = 1'b1; m_key.delete();
            if (m_data.size() == 4) present();
          end
        end else begin
          m_data.push_back(veri);
          if (m_data.size() == 4) begin
            m_blok1 = pack(m_data, 1'b1); m_blok0 = pack(m_data, 1'b0);
            if (m_kv) present();
          end
        end
      end
    end
    #1;
  endtask

  task automatic send(input bit tur, input logic [31:0] veri, input bit hz);
    bit a = 1'b0;
    int n = 0;
    while (!a && n < 50) begin
      step(1'b1, tur, veri, hz, 1'b0, a);
      n++;
    end
    if (!a) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual=not accepted required=accepted");
    end
  endtask

  task automatic idle(input bit hz);
    bit a;
    step(1'b0, 1'b0, 32'h0, hz, 1'b0, a);
  endtask

  task automatic do_reset();
    if0.s_gecerli = 1'b0; if0.temizle = 1'b0; if0.hazir = 1'b0;
    if0.s_tur = 1'b0; if0.s_veri = '0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_s_hazir", if0.s_hazir, 1'b1);
    chk("rst_g_gecerli", if0.g_gecerli, 1'b0);
    chk("rst_anahtar_gecerli", if0.anahtar_gecerli, 1'b0);
    chk("rst_anahtar", if0.anahtar, 128'h0);
    chk("rst_blok", if0.blok, 128'h0);
    chk("rst_blok_sayisi", if0.blok_sayisi, 16'h0);
    chk("rst_durum", if0.durum, TOPLA);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && if0.g_gecerli && if0.hazir && !if0.temizle) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected: actual=transfer required=none blok=%0h", if0.blok);
      end else begin
        chk("xfer_msb", {if0.blok, if0.anahtar}, exp_q1.pop_front());
      end
    end
    if (!rst && if1.g_gecerli && if1.hazir && !if1.temizle) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL xfer_unexpected_lsb: actual=transfer required=none blok=%0h", if1.blok);
      end else begin
        chk("xfer_lsb", {if1.blok, if1.anahtar}, exp_q0.pop_front());
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    bit a;
    int n;
    logic [15:0] c0;
    logic [31:0] keys[4];
    logic [31:0] dat[4];
    keys = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    dat  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    rst = 1'b1;
    if0.s_gecerli = 1'b0; if0.temizle = 1'b0; if0.hazir = 1'b0;
    if0.s_tur = 1'b0; if0.s_veri = '0;
    @(posedge clk); #1;
    do_reset();

    // Known-answer block: key then data, engine ready
    foreach (keys[i]) send(1'b1, keys[i], 1'b1);
    foreach (dat[i]) send(1'b0, dat[i], 1'b1);
    chk("kat_g_gecerli", if0.g_gecerli, 1'b1);
    chk("kat_anahtar", if0.anahtar, 128'h000102030405060708090a0b0c0d0e0f);
    chk("kat_blok", if0.blok, 128'h00112233445566778899aabbccddeeff);
    chk("kat_blok_lsb", if1.blok, 128'hccddeeff8899aabb4455667700112233);
    chk("kat_anahtar_lsb", if1.anahtar, 128'h0c0d0e0f08090a0b0405060700010203);
    idle(1'b1);
    chk("kat_g_low", if0.g_gecerli, 1'b0);
    chk("kat_count", if0.blok_sayisi, 16'd1);

    // Data before key, then engine stalls for 10 cycles
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, $urandom, 1'b0);
    chk("wait_durum", if0.durum, ANAHTAR_BEKLE);
    step(1'b1, 1'b0, $urandom, 1'b0, 1'b0, a);
    chk("wait_data_refused", a, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, $urandom, 1'b0);
    chk("wait_g_after_key", if0.g_gecerli, 1'b1);
    repeat (10) idle(1'b0);
    chk("stall_g", if0.g_gecerli, 1'b1);
    idle(1'b1);
    #3;
    chk("stall_release_s_hazir", if0.s_hazir, 1'b1);
    #(-0);

    // Back-to-back blocks with valid and ready held high
    c0 = m_cnt;
    n = 0;
    while (m_cnt != c0 + 16'd3 && n < 40) begin
      step(1'b1, 1'b0, $urandom, 1'b1, 1'b0, a);
      n++;
    end
    chk("b2b_cycles", n, 15);
    chk("b2b_count", if0.blok_sayisi, c0 + 16'd3);

    // Flush after two data words, then a fresh block
    send(1'b0, 32'hdeadbeef, 1'b0);
    send(1'b0, 32'hcafef00d, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a);
    send(1'b0, 32'h0000000a, 1'b0);
    send(1'b0, 32'h0000000b, 1'b0);
    send(1'b0, 32'h0000000c, 1'b0);
    send(1'b0, 32'h0000000d, 1'b0);
    chk("flush_blok", if0.blok, 128'h0000000a0000000b0000000c0000000d);
    c0 = m_cnt;
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, a);
    chk("flush_xfer_not_counted", if0.blok_sayisi, c0);
    chk("flush_g_low", if0.g_gecerli, 1'b0);

    // Reset in the middle of a key
    send(1'b1, $urandom, 1'b0);
    send(1'b1, $urandom, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, $urandom, 1'b0);
    chk("rst_key_discarded", if0.durum, ANAHTAR_BEKLE);
    for (int i = 0; i < 4; i++) send(1'b1, $urandom, 1'b0);
    idle(1'b1);

    // Block counter wrap
    force u0.blok_cnt = 16'hffff;
    force u1.blok_cnt = 16'hffff;
    #1;
    release u0.blok_cnt;
    release u1.blok_cnt;
    m_cnt = 16'hffff;
    for (int i = 0; i < 4; i++) send(1'b0, $urandom, 1'b1);
    idle(1'b1);
    chk("wrap_count", if0.blok_sayisi, 16'h0000);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0, a);
    end

    // Drain
    n = 0;
    while (m_pres && n < 5) begin
      idle(1'b1);
      n++;
    end
    idle(1'b0);
    chk("drain_q_msb", exp_q1.size(), 0);
    chk("drain_q_lsb", exp_q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
AES_BLOCK_PACKER -- requirements
Module: aes_block_packer

Interface
REQ-001 SHALL have parameter FIRST_WORD_MSB, default 1: 1 = first accepted word lands in bits [127:96]; 0 = first word lands in [31:0].
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_veri  input  32  incoming word.
REQ-005 SHALL have port s_tur  input  1  word type: 0 = data, 1 = key.
REQ-006 SHALL have port s_gecerli  input  1  s_veri/s_tur valid.
REQ-007 SHALL have port s_hazir  output  1  packer accepts the offered word.
REQ-008 SHALL have port temizle  input  1  synchronous flush.
REQ-009 SHALL have port anahtar  output  128  committed key to engine.
REQ-010 SHALL have port blok  output  128  assembled plaintext block to engine.
REQ-011 SHALL have port g_gecerli  output  1  blok/anahtar valid to engine.
REQ-012 SHALL have port hazir  input  1  engine ready.
REQ-013 SHALL have port anahtar_gecerli  output  1  a full key has been committed since reset.
REQ-014 SHALL have port blok_sayisi  output  16  count of blocks transferred to engine.

Function
REQ-015 Word accepted SHALL mean s_gecerli & s_hazir in the same cycle; block transferred SHALL mean g_gecerli & hazir.
REQ-016 FSM SHALL have states TOPLA (collect), ANAHTAR_BEKLE (4 data words held, no key), GONDER (presenting).
REQ-017 s_hazir SHALL be combinational: 1 in TOPLA; s_tur in ANAHTAR_BEKLE; 0 in GONDER.
REQ-018 Data and key SHALL each have a 2-bit word counter, wrapping 3->0 on the 4th accepted word of its type.
REQ-019 Key words SHALL fill a staging register; on the 4th key word, staging SHALL copy to anahtar and anahtar_gecerli SHALL set, both visible the next cycle; anahtar SHALL never show a partial key.
REQ-020 4th data word accepted in cycle N: if anahtar_gecerli=1 at N, state SHALL be GONDER with g_gecerli=1 at N+1; else state SHALL be ANAHTAR_BEKLE.
REQ-021 In ANAHTAR_BEKLE, commit of the 4th key word SHALL move to GONDER, g_gecerli=1 the cycle after the commit.
REQ-022 In GONDER, blok and anahtar SHALL be stable until transfer; on transfer, state SHALL return to TOPLA next cycle, g_gecerli=0, data counter 0, blok_sayisi +1.
REQ-023 blok_sayisi SHALL wrap 0xFFFF -> 0x0000.
REQ-024 A key update SHALL NOT occur while in GONDER (no key words accepted there).
REQ-025 temizle=1 SHALL take priority over any accept/transfer that cycle: next cycle state TOPLA, both counters 0, key staging discarded, g_gecerli=0; anahtar, anahtar_gecerli, blok_sayisi retained; a transfer in the same cycle SHALL NOT count.
REQ-026 Minimum period SHALL be 5 cycles per block (4 accepts + 1 transfer cycle) with hazir held 1.

Reset
REQ-027 rst=1 SHALL asynchronously force state TOPLA, counters 0, anahtar/blok/staging 0, anahtar_gecerli 0, g_gecerli 0, blok_sayisi 0; s_hazir SHALL therefore be 1.
REQ-028 rst asserted mid-block or mid-key SHALL discard all partial and committed content; first word after deassertion SHALL be treated as word 0.

Structure
REQ-029 Shared package aes_pkg SHALL hold BLOCK_W=128, WORD_W=32, WORDS_PER_BLOCK=4, and the FSM state encoding.
REQ-030 Sub-module aes_word_packer (4x32 -> 128 assembler with load/clear, honouring FIRST_WORD_MSB) SHALL be instantiated twice: data and key staging.

Verification
REQ-031 Key words 0x00010203,0x04050607,0x08090a0b,0x0c0d0e0f, then data 0x00112233,0x44556677,0x8899aabb,0xccddeeff, hazir=1 -> anahtar=0x000102030405060708090a0b0c0d0e0f, blok=0x00112233445566778899aabbccddeeff, g_gecerli high exactly one cycle, blok_sayisi=1.
REQ-032 Data before key: 4 data words -> state ANAHTAR_BEKLE, s_hazir=0 for s_tur=0 and 1 for s_tur=1, g_gecerli=0; after 4 key words -> g_gecerli=1 the next cycle.
REQ-033 hazir held 0 for 10 cycles in GONDER -> g_gecerli, blok, anahtar unchanged, s_hazir=0; hazir=1 -> transfer, s_hazir=1 the next cycle.
REQ-034 Back-to-back: 3 blocks, s_gecerli and hazir held 1 -> g_gecerli pulses 5 cycles apart, blok_sayisi=3; FIRST_WORD_MSB=0 run -> blok=0xccddeeff8899aabb4455667700112233.
REQ-035 temizle after 2 data words, then 4 new words 0xA..0xD -> blok=0x0000000a0000000b0000000c0000000d; rst after 2 key words -> anahtar_gecerli=0, anahtar=0.
REQ-036 Preload blok_sayisi to 0xFFFF via 65535 transfers (or force), one more transfer -> 0x0000.
